// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Grant is registered; ready/strobe/data are combinational from the grant (no added latency).

module fifo_wr_arb_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  grant,
  input  logic                  full,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  own_vld,
  output logic                  own_last,
  output logic [DATA_WIDTH-1:0] own_data
);
  assign ready    = grant & ~full;
  assign own_vld  = grant & valid;
  assign own_last = grant & valid & last;
  assign own_data = grant ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic                          BUSY
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                             state_q, state_d;
  logic [NUM_REQ-1:0]                 grant_q, grant_d;
  logic [PW-1:0]                      rr_q, rr_d;
  logic [CW-1:0]                      cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0]                 own_vld, own_last;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] own_data;
  logic                               owner_vld, owner_last, beat, release_c;
  logic                               win_found;
  logic [PW-1:0]                      win_idx, scan;

  fifo_wr_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane [NUM_REQ-1:0] (
    .grant    (grant_q),
    .full     (FULL),
    .valid    (REQ_VALID),
    .last     (REQ_LAST),
    .data     (REQ_DATA),
    .ready    (REQ_READY),
    .own_vld  (own_vld),
    .own_last (own_last),
    .own_data (own_data)
  );

  always_comb begin
    WR_DATA = '0;
    for (int i = 0; i < NUM_REQ; i++) WR_DATA = WR_DATA | own_data[i];
  end

  assign owner_vld  = |own_vld;
  assign owner_last = |own_last;
  assign beat       = owner_vld & ~FULL;
  assign W_INC      = beat;
  assign GRANT      = grant_q;
  assign BUSY       = |grant_q;
  assign cnt_inc    = cnt_q + CW'(beat);

  // A FULL stall with valid held is not a bubble, so FULL never forces a release.
  assign release_c = (state_q == OWN) &&
                     ((beat && owner_last) ||
                      (beat && (cnt_inc == CW'(MAX_BURST))) ||
                      (!owner_vld && !FULL));

  // Scan starts after the last winner, so a releasing owner is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (scan == PW'(NUM_REQ - 1)) ? '0 : scan + PW'(1);
      if (!win_found && REQ_VALID[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (state_q == OWN) cnt_d = cnt_inc;
    if (state_q == IDLE || release_c) begin
      cnt_d = '0;
      if (win_found) begin
        state_d          = OWN;
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        rr_d             = win_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed multi-cycle sequences and
// randomized packet traffic checked against a packet-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 8;

  logic            CLK = 1'b0, RST = 1'b0, FULL = 1'b0;
  logic [N-1:0]    REQ_VALID = '0, REQ_LAST = '0;
  logic [N*DW-1:0] REQ_DATA = '0;
  logic [N-1:0]    REQ_READY, GRANT;
  logic            W_INC, BUSY;
  logic [DW-1:0]   WR_DATA;

  always #5 CLK = ~CLK;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST),
    .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .FULL(FULL), .W_INC(W_INC),
    .WR_DATA(WR_DATA), .GRANT(GRANT), .BUSY(BUSY)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester obligation: data/last stable while valid and not yet accepted.
  logic [N-1:0]    p_v, p_r, p_l;
  logic [N*DW-1:0] p_d;
  always @(posedge CLK) begin
    if (RST) p_v <= '0;
    else begin
      for (int i = 0; i < N; i++)
        if (p_v[i] && !p_r[i] && REQ_VALID[i])
          assert (REQ_LAST[i] == p_l[i] && REQ_DATA[i*DW +: DW] == p_d[i*DW +: DW])
            else $error("requester %0d changed data while stalled", i);
      p_v <= REQ_VALID;
    end
    p_r <= REQ_READY; p_l <= REQ_LAST; p_d <= REQ_DATA;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] v, l; logic f;
    logic [N-1:0] g; logic wi; logic [N-1:0] rdy; logic [DW-1:0] wd;
  } vec_t;
  vec_t tbl[16];

  // ---------------- packet sources + reference model ----------------
  logic [DW:0]  mem[N][64];
  int           hd[N], tl[N];
  logic [N-1:0] en;
  logic         full_drv;
  int           m_own, m_cnt, m_ptr, cyc;
  int           glog[$], bid[$], bcyc[$];
  logic [DW-1:0] bdat[$];
  logic [N-1:0] prev_g;
  bit           stall_mon;
  int           stall_bad;

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic push(input int i, input int len, input logic [DW-1:0] base);
    for (int b = 0; b < len; b++) begin
      mem[i][tl[i] % 64] = {b == len - 1, base + DW'(b)};
      tl[i]++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    en = '0; full_drv = 1'b0;
    m_own = -1; m_cnt = 0; m_ptr = N - 1;
    glog.delete(); bid.delete(); bdat.delete(); bcyc.delete();
    prev_g = '0;
  endtask

  task automatic drive();
    logic [DW:0] e;
    for (int i = 0; i < N; i++) begin
      e = (hd[i] != tl[i]) ? mem[i][hd[i] % 64] : '0;
      REQ_VALID[i] = en[i] && (hd[i] != tl[i]);
      REQ_LAST[i]  = e[DW];
      REQ_DATA[i*DW +: DW] = e[DW-1:0];
    end
    FULL = full_drv;
  endtask

  // One clock: drive at edge+1, check at negedge, advance model, wait for next edge+1.
  task automatic cycle();
    logic [N-1:0]  exp_g;
    logic          exp_w, rel;
    logic [DW-1:0] exp_d;
    int            win;
    drive();
    #4;
    exp_g = '0; exp_w = 1'b0; exp_d = '0;
    if (m_own >= 0) begin
      exp_g[m_own] = 1'b1;
      exp_w = REQ_VALID[m_own] && !FULL;
      exp_d = REQ_DATA[m_own*DW +: DW];
    end
    chk($sformatf("c%0d grant", cyc), GRANT, exp_g);
    chk($sformatf("c%0d w_inc", cyc), W_INC, exp_w);
    chk($sformatf("c%0d ready", cyc), REQ_READY, FULL ? '0 : exp_g);
    chk($sformatf("c%0d busy", cyc), BUSY, exp_g != '0);
    chk($sformatf("c%0d wr_data", cyc), WR_DATA, exp_d);
    if (stall_mon && (W_INC !== 1'b0 || REQ_READY !== '0 || GRANT !== 4'b0001)) stall_bad++;
    if (GRANT != '0 && GRANT != prev_g) glog.push_back(oh2i(GRANT));
    prev_g = GRANT;
    if (W_INC === 1'b1) begin
      bid.push_back(oh2i(GRANT)); bdat.push_back(WR_DATA); bcyc.push_back(cyc);
    end
    rel = 1'b1;
    if (m_own >= 0) begin
      if (exp_w) begin hd[m_own]++; m_cnt++; end
      rel = (exp_w && REQ_LAST[m_own]) || (m_cnt == MB) || (!REQ_VALID[m_own] && !FULL);
    end
    if (rel) begin
      win = -1;
      for (int k = 1; k <= N; k++)
        if (win < 0 && REQ_VALID[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      m_own = win; m_cnt = 0;
      if (win >= 0) m_ptr = win;
    end
    cyc++;
    @(posedge CLK); #1;
  endtask

  task automatic run_until(input string name, input int nbeats, input int budget);
    int c = 0;
    while (bid.size() < nbeats && c < budget) begin cycle(); c++; end
    chk({name, " beats"}, bid.size(), nbeats);
  endtask

  task automatic reset_all();
    RST = 1'b1;
    model_clear();
    drive();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  function automatic int at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e2[5];
    stall_mon = 0; stall_bad = 0; cyc = 0;
    model_clear();
    //              v        l        f     g        wi    rdy      wd
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA5};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA5};
    tbl[3]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA5};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0001, 8'hA5};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
    tbl[6]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
    tbl[7]  = '{4'b1001, 4'b1000, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'hA5};
    tbl[8]  = '{4'b1000, 4'b1000, 1'b0, 4'b0001, 1'b0, 4'b0001, 8'hA5};
    tbl[9]  = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'b1000, 8'h3D};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b1000, 8'h3D};
    tbl[11] = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};
    tbl[12] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0000, 8'h2C};
    tbl[13] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'h2C};
    tbl[14] = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0100, 8'h2C};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};

    // async reset takes effect before any clock edge
    REQ_VALID = 4'b1111;
    REQ_DATA  = {8'h3D, 8'h2C, 8'h1B, 8'hA5};
    #1 RST = 1'b1;
    #2;
    chk("rst grant", GRANT, 0);
    chk("rst w_inc", W_INC, 0);
    chk("rst ready", REQ_READY, 0);
    chk("rst busy", BUSY, 0);
    REQ_VALID = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    for (int r = 0; r < 16; r++) begin
      REQ_VALID = tbl[r].v; REQ_LAST = tbl[r].l; FULL = tbl[r].f;
      #4;
      chk($sformatf("tbl%0d grant", r), GRANT, tbl[r].g);
      chk($sformatf("tbl%0d w_inc", r), W_INC, tbl[r].wi);
      chk($sformatf("tbl%0d ready", r), REQ_READY, tbl[r].rdy);
      chk($sformatf("tbl%0d busy", r), BUSY, tbl[r].g != '0);
      chk($sformatf("tbl%0d wr_data", r), WR_DATA, tbl[r].wd);
      @(posedge CLK); #1;
    end

    // all four valid, 2-beat packets: rotation with back-to-back handoff
    reset_all();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 3; p++) push(i, 2, DW'(8'h10 * i + 2 * p));
    en = 4'b1111;
    run_until("t2", 24, 60);
    e2 = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) chk($sformatf("t2 order%0d", k), at(glog, k), e2[k]);
    chk("t2 gaps", (bcyc.size() == 24) ? bcyc[23] - bcyc[0] + 1 - 24 : -1, 0);
    repeat (3) cycle();

    // long packet forced off after MAX_BURST beats, resumes after the other requester
    reset_all();
    push(1, 20, 8'h40); push(2, 3, 8'h80);
    en = 4'b0110;
    run_until("t3", 23, 60);
    chk("t3 g0", at(glog, 0), 1);
    chk("t3 g1", at(glog, 1), 2);
    chk("t3 g2", at(glog, 2), 1);
    chk("t3 beat8 id", at(bid, 7), 1);
    chk("t3 beat9 id", at(bid, 8), 2);
    chk("t3 beat11 id", at(bid, 10), 2);
    chk("t3 beat12 id", at(bid, 11), 1);
    chk("t3 beat12 data", (bdat.size() > 11) ? bdat[11] : 8'hxx, 8'h48);
    repeat (3) cycle();

    // FULL stall mid-burst: nothing moves, burst count not advanced
    reset_all();
    push(0, 10, 8'h20); push(1, 2, 8'h60);
    en = 4'b0011;
    repeat (3) cycle();
    chk("t4 beats before stall", bid.size(), 2);
    full_drv = 1'b1; stall_mon = 1;
    repeat (5) cycle();
    stall_mon = 0; full_drv = 1'b0;
    chk("t4 stall", stall_bad, 0);
    chk("t4 beats during stall", bid.size(), 2);
    run_until("t4", 12, 40);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t4 data%0d", k), (bdat.size() > k) ? bdat[k] : 8'hxx, 8'h20 + k);
    chk("t4 release after 8", at(bid, 8), 1);
    chk("t4 resume data", (bdat.size() > 10) ? bdat[10] : 8'hxx, 8'h28);
    repeat (3) cycle();

    // reset in the middle of beat 2
    reset_all();
    push(0, 4, 8'hC0);
    en = 4'b0001;
    repeat (2) cycle();
    drive();
    #2 RST = 1'b1;
    #1;
    chk("t6 grant", GRANT, 0);
    chk("t6 w_inc", W_INC, 0);
    chk("t6 ready", REQ_READY, 0);
    chk("t6 busy", BUSY, 0);
    @(posedge CLK); #1;
    model_clear();
    push(0, 2, 8'hC8); push(2, 2, 8'hE0);
    en = 4'b0101;
    RST = 1'b0;
    run_until("t6", 4, 20);
    chk("t6 first winner", at(glog, 0), 0);
    chk("t6 first data", (bdat.size() > 0) ? bdat[0] : 8'hxx, 8'hC8);

    // randomized traffic against the model
    reset_all();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (tl[i] - hd[i] < 8) push(i, 1 + int'($urandom % 12), DW'($urandom));
      for (int i = 0; i < N; i++) en[i] = ($urandom % 5) != 0;
      full_drv = ($urandom % 5) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
